if_id_skid: RTL
===============

IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 The block SHALL have parameter INSTR_WIDTH, default 32, giving the instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 14, giving the return address width in bits.
REQ-003 clock  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-004 nreset  input  1  reset; asynchronous, active-low.
REQ-005 flush  input  1  synchronous pipeline flush, for example on a taken branch.
REQ-006 in_valid  input  1  the fetch stage presents a valid word.
REQ-007 in_ready  output  1  the block can accept a word this cycle.
REQ-008 instruction_in  input  INSTR_WIDTH  fetched instruction word.
REQ-009 return_addr_in  input  ADDR_WIDTH  return address for the fetched word.
REQ-010 take_branch_addr_in  input  1  branch-address select flag for the fetched word.
REQ-011 out_valid  output  1  the decode-side word is valid.
REQ-012 out_ready  input  1  the decode stage consumes the word this cycle.
REQ-013 instruction_out  output  INSTR_WIDTH  instruction word to the decode stage.
REQ-014 return_addr_out  output  ADDR_WIDTH  return address to the decode stage.
REQ-015 take_branch_addr_out  output  1  registered branch flag, travelling with its instruction.
REQ-016 stall_count  output  16  count of stall cycles; present only when IF_ID_STALL_COUNT_EN is defined.

Function
REQ-017 The block SHALL hold a main register and a skid register; each SHALL store an instruction, a return address and a branch flag.
REQ-018 Control SHALL be a state machine with states EMPTY, ONE (main register valid) and FULL (main and skid registers valid).
REQ-019 An input is accepted when in_valid=1 and in_ready=1; a word is consumed when out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; it SHALL be decoded from the state register only, with no combinational path from out_ready.
REQ-021 out_valid SHALL be 1 in ONE and FULL; all *_out signals SHALL be driven from the main register.
REQ-022 EMPTY, on accept: go to ONE and load the input into the main register; latency from accept to out_valid is 1 cycle.
REQ-023 ONE, on accept and consume together: stay in ONE and load the input into the main register.
REQ-024 ONE, on accept without consume: go to FULL and load the input into the skid register.
REQ-025 ONE, on consume without accept: go to EMPTY and clear the main register to zero.
REQ-026 FULL, on consume: go to ONE, move the skid register into the main register and clear the skid register.
REQ-027 In any state with no accept and no consume, the state and all registers SHALL hold.
REQ-028 flush=1 SHALL take priority over all other events: next state EMPTY, both registers zeroed, and any input presented that cycle dropped.
REQ-029 In EMPTY, instruction_out SHALL be all zeros (NOP), and return_addr_out and take_branch_addr_out SHALL be 0.
REQ-030 Words SHALL leave in acceptance order, with none lost or duplicated, under any pattern of out_ready.

Reset
REQ-031 nreset=0 SHALL immediately force state EMPTY, zero both registers and clear stall_count, without waiting for a clock edge.
REQ-032 While nreset=0, the outputs SHALL be: out_valid=0, in_ready=1, and all data outputs 0.
REQ-033 Reset asserted mid-transfer SHALL discard all held words; after release, operation SHALL resume from EMPTY.

Configuration
REQ-034 With IF_ID_STALL_COUNT_EN defined, stall_count SHALL increment on each cycle with out_valid=1 and out_ready=0, and SHALL saturate at 16'hFFFF.
REQ-035 stall_count SHALL be unaffected by flush.
REQ-036 Without IF_ID_STALL_COUNT_EN, the stall_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-037 Reset scenario: reset, then accept 0x00000013 with out_ready=1 -> the next cycle shows out_valid=1 and instruction_out=0x00000013.
REQ-038 Back-pressure scenario: hold out_ready=0 and offer A and then B -> FULL, in_ready=0; raise out_ready -> A then B are output on consecutive cycles.
REQ-039 Flush scenario: in FULL, assert flush with in_valid=1 and word C -> the next cycle shows EMPTY, out_valid=0, instruction_out=0, and C is never output.
REQ-040 Throughput scenario: in_valid=1 and out_ready=1 for 100 cycles -> 100 words are transferred in order with in_ready constantly 1.
REQ-041 Asynchronous reset scenario: assert nreset=0 between clock edges while in FULL -> out_valid=0 and in_ready=1 before the next edge.
REQ-042 Counter scenario (IF_ID_STALL_COUNT_EN defined): 70000 stalled cycles -> stall_count=16'hFFFF.

Source files
------------

// File: rtl/if_id_skid_if.sv
// IF/ID handshake bundle: fetch-side word in, decode-side word out.
// slave is the skid block's view; master is the surrounding pipeline's view.
interface if_id_skid_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 14
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] instruction_in;
  logic [ADDR_WIDTH-1:0]  return_addr_in;
  logic                   take_branch_addr_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] instruction_out;
  logic [ADDR_WIDTH-1:0]  return_addr_out;
  logic                   take_branch_addr_out;

  modport slave (
    input  in_valid, instruction_in, return_addr_in, take_branch_addr_in, out_ready,
    output in_ready, out_valid, instruction_out, return_addr_out, take_branch_addr_out
  );

  modport master (
    output in_valid, instruction_in, return_addr_in, take_branch_addr_in, out_ready,
    input  in_ready, out_valid, instruction_out, return_addr_out, take_branch_addr_out
  );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a one-entry skid buffer; 1-cycle accept-to-valid latency.
// in_ready comes only from state, so out_ready never reaches it combinationally. IF_ID_STALL_COUNT_EN adds stall_count.
module if_id_skid #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 14
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        flush,
  if_id_skid_if.slave bus
`ifdef IF_ID_STALL_COUNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   br;
  } word_t;

  state_t state_q, state_d;
  word_t  main_q, main_d;
  word_t  skid_q, skid_d;
  word_t  in_word;
  logic   in_ready_w, out_valid_w, accept, consume;

  assign in_word     = '{instr: bus.instruction_in, addr: bus.return_addr_in, br: bus.take_branch_addr_in};
  assign in_ready_w  = (state_q != FULL);
  assign out_valid_w = (state_q != EMPTY);
  assign accept      = bus.in_valid & in_ready_w;
  assign consume     = out_valid_w & bus.out_ready;

  // Main register is kept zero whenever EMPTY, so outputs read NOP without extra muxing.
  assign bus.in_ready             = in_ready_w;
  assign bus.out_valid            = out_valid_w;
  assign bus.instruction_out      = main_q.instr;
  assign bus.return_addr_out      = main_q.addr;
  assign bus.take_branch_addr_out = main_q.br;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_word;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_word;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_word;
          end else if (consume) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        FULL: begin
          if (consume) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef IF_ID_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles where decode holds off a valid word; flush does not touch it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid_w && !bus.out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule
